// File: rtl/matrix_inverse_seq.sv
// Sequential 2x2 matrix inverse helper: produces the adjugate and determinant of a
// signed 2x2 matrix over a four-state pipeline, with valid/ready handshakes on both sides.
module matrix_inverse_seq #(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic signed [W-1:0]  d11,
  input  logic signed [W-1:0]  d12,
  input  logic signed [W-1:0]  d21,
  input  logic signed [W-1:0]  d22,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic signed [W:0]    adj11,
  output logic signed [W:0]    adj12,
  output logic signed [W:0]    adj21,
  output logic signed [W:0]    adj22,
  output logic signed [2*W:0]  det,
  output logic                 singular,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_W-1:0]     singular_cnt,
  output logic [1:0]           state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // in_ready is high only in IDLE; out_valid is high only in OUT, where the result is
  // held stable until out_ready is seen.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_SUB  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic signed [W-1:0]   r11, r12, r21, r22;
  logic signed [2*W-1:0] p1, p2;
  logic signed [2*W:0]   det_next;
  logic signed [W:0]     neg12, neg21;
  logic                  accept;
  logic                  consume;

  assign accept  = (state == S_IDLE) && in_valid;
  assign consume = (state == S_OUT) && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (in_valid) state_next = S_MUL;
      S_MUL:   state_next = S_SUB;
      S_SUB:   state_next = S_OUT;
      S_OUT:   if (out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_OUT);
    state_dbg = state;
  end

  // Operand and product registers carry no reset: they are always written before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      r11 <= d11;
      r12 <= d12;
      r21 <= d21;
      r22 <= d22;
    end
    if (state == S_MUL) begin
      p1 <= (2*W)'(r11) * (2*W)'(r22);
      p2 <= (2*W)'(r12) * (2*W)'(r21);
    end
  end

  // One extra bit on each side keeps -2^(W-1) and the product difference exact.
  assign det_next = (2*W+1)'(p1) - (2*W+1)'(p2);
  assign neg12    = -((W+1)'(r12));
  assign neg21    = -((W+1)'(r21));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      det      <= '0;
      adj11    <= '0;
      adj12    <= '0;
      adj21    <= '0;
      adj22    <= '0;
      singular <= 1'b0;
    end else if (state == S_SUB) begin
      det <= det_next;
      if (det_next == '0) begin
        adj11    <= '0;
        adj12    <= '0;
        adj21    <= '0;
        adj22    <= '0;
        singular <= 1'b1;
      end else begin
        adj11    <= (W+1)'(r22);
        adj12    <= neg12;
        adj21    <= neg21;
        adj22    <= (W+1)'(r11);
        singular <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      singular_cnt <= '0;
    end else if (consume && singular && (singular_cnt != {CNT_W{1'b1}})) begin
      singular_cnt <= singular_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_matrix_inverse_seq.sv
// Bench for matrix_inverse_seq: directed and random matrices checked against an
// integer-arithmetic reference; a second instance with a 2-bit counter checks saturation.
module tb_matrix_inverse_seq;

  localparam int W = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] d11, d12, d21, d22;
  logic       in_valid;
  logic       out_ready;

  logic       in_ready, singular, out_valid;
  logic [4:0] adj11, adj12, adj21, adj22;
  logic [8:0] det;
  logic [7:0] singular_cnt;
  logic [1:0] state_dbg;

  logic       c2_in_ready, c2_singular, c2_out_valid;
  logic [4:0] c2_adj11, c2_adj12, c2_adj21, c2_adj22;
  logic [8:0] c2_det;
  logic [1:0] c2_singular_cnt;
  logic [1:0] c2_state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt8 = 0;
  int exp_cnt2 = 0;
  logic [8:0] prev_det = '0;
  logic [8:0] exp_q[$];

  matrix_inverse_seq #(.W(W), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .d11(d11), .d12(d12), .d21(d21), .d22(d22),
    .in_valid(in_valid), .in_ready(in_ready),
    .adj11(adj11), .adj12(adj12), .adj21(adj21), .adj22(adj22),
    .det(det), .singular(singular), .out_valid(out_valid), .out_ready(out_ready),
    .singular_cnt(singular_cnt), .state_dbg(state_dbg)
  );

  matrix_inverse_seq #(.W(W), .CNT_W(2)) dut_c2 (
    .clk(clk), .rst_n(rst_n),
    .d11(d11), .d12(d12), .d21(d21), .d22(d22),
    .in_valid(in_valid), .in_ready(c2_in_ready),
    .adj11(c2_adj11), .adj12(c2_adj12), .adj21(c2_adj21), .adj22(c2_adj22),
    .det(c2_det), .singular(c2_singular), .out_valid(c2_out_valid), .out_ready(out_ready),
    .singular_cnt(c2_singular_cnt), .state_dbg(c2_state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Drive one matrix through the block and check every cycle until it is consumed.
  task automatic run_matrix(input int a, input int b, input int c, input int d, input int stall);
    int         det_i;
    logic       e_s;
    logic [4:0] e11, e12, e21, e22;
    logic [8:0] q_det;
    det_i = a * d - b * c;
    e_s   = (det_i == 0);
    e11   = e_s ? 5'd0 : 5'(d);
    e12   = e_s ? 5'd0 : 5'(-b);
    e21   = e_s ? 5'd0 : 5'(-c);
    e22   = e_s ? 5'd0 : 5'(a);
    check("in_ready_idle", 64'(in_ready), 64'(1));
    d11 = 4'(a); d12 = 4'(b); d21 = 4'(c); d22 = 4'(d);
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    exp_q.push_back(9'(det_i));
    tick();
    in_valid = 1'($urandom_range(0, 1));
    d11 = 4'($urandom); d12 = 4'($urandom); d21 = 4'($urandom); d22 = 4'($urandom);
    check("out_valid_mul", 64'(out_valid), 64'(0));
    check("in_ready_mul", 64'(in_ready), 64'(0));
    check("det_hold_mul", 64'(det), 64'(prev_det));
    tick();
    check("out_valid_sub", 64'(out_valid), 64'(0));
    tick();
    check("out_valid_latency", 64'(out_valid), 64'(1));
    check("in_ready_out", 64'(in_ready), 64'(0));
    q_det = exp_q.pop_front();
    check("det", 64'(det), 64'(q_det));
    check("adj11", 64'(adj11), 64'(e11));
    check("adj12", 64'(adj12), 64'(e12));
    check("adj21", 64'(adj21), 64'(e21));
    check("adj22", 64'(adj22), 64'(e22));
    check("singular", 64'(singular), 64'(e_s));
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      d11 = 4'($urandom);
      tick();
      check("stall_out_valid", 64'(out_valid), 64'(1));
      check("stall_in_ready", 64'(in_ready), 64'(0));
      check("stall_det", 64'(det), 64'(q_det));
      check("stall_adj12", 64'(adj12), 64'(e12));
      check("stall_singular", 64'(singular), 64'(e_s));
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    if (e_s) begin
      exp_cnt8 = min_int(exp_cnt8 + 1, 255);
      exp_cnt2 = min_int(exp_cnt2 + 1, 3);
    end
    check("consume_out_valid", 64'(out_valid), 64'(0));
    check("consume_in_ready", 64'(in_ready), 64'(1));
    check("retain_det", 64'(det), 64'(q_det));
    check("retain_adj21", 64'(adj21), 64'(e21));
    check("singular_cnt", 64'(singular_cnt), 64'(exp_cnt8));
    check("singular_cnt_c2", 64'(c2_singular_cnt), 64'(exp_cnt2));
    prev_det = q_det;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    d11 = '0; d12 = '0; d21 = '0; d22 = '0;
    tick();
    tick();
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_det", 64'(det), 64'(0));
    check("rst_adj", 64'({adj11, adj12, adj21, adj22}), 64'(0));
    check("rst_singular", 64'(singular), 64'(0));
    check("rst_cnt", 64'(singular_cnt), 64'(0));
    rst_n = 1'b1;
    tick();

    run_matrix(3, 1, 2, 4, 0);
    run_matrix(2, 4, 1, 2, 0);
    run_matrix(-8, -8, 7, -8, 0);
    run_matrix(1, 2, 3, 4, 5);
    run_matrix(1, 1, 1, 1, 0);
    run_matrix(0, 0, 0, 0, 0);
    run_matrix(-8, -8, -8, -8, 2);
    run_matrix(2, -3, 4, -6, 0);
    run_matrix(-8, 7, -8, 7, 1);

    for (int k = 0; k < 24; k++) begin
      run_matrix(int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8,
                 int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8,
                 int'($urandom_range(0, 2)));
    end

    // Reset while the matrix sits in SUB, with in_valid also high at the reset edges.
    d11 = 4'(5); d12 = 4'(1); d21 = 4'(1); d22 = 4'(5);
    in_valid = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    exp_cnt8 = 0; exp_cnt2 = 0; prev_det = '0;
    exp_q.delete();
    check("rst_sub_out_valid", 64'(out_valid), 64'(0));
    check("rst_sub_det", 64'(det), 64'(0));
    check("rst_sub_cnt", 64'(singular_cnt), 64'(0));
    check("rst_sub_cnt_c2", 64'(c2_singular_cnt), 64'(0));
    tick();
    check("rst_prio_in_ready", 64'(in_ready), 64'(1));
    rst_n = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_out_valid", 64'(out_valid), 64'(0));
      check("post_rst_in_ready", 64'(in_ready), 64'(1));
    end
    run_matrix(3, 1, 2, 4, 0);
    run_matrix(4, 2, 6, 3, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
